// File: rtl/bw_io_cmos2_pkg.sv
// Shared types and sizing for the CMOS2 bidirectional pad controller.
package bw_io_cmos2_pkg;

    typedef enum logic [1:0] {
        ST_RX    = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } pad_st_t;

    localparam int FILT_CYC_DEF = 8;
    localparam int TA_CYC_DEF   = 2;

    // Filter counters reach at most FILT_CYC-1 (<=14), turnaround at most TA_CYC-1 (<=6).
    localparam int FILT_CW = 4;
    localparam int TA_CW   = 3;

endpackage

// File: rtl/bw_io_cmos2_rx_filt.sv
// Receive path: 2-flop synchroniser, settle/glitch filter and edge pulses.
module bw_io_cmos2_rx_filt
    import bw_io_cmos2_pkg::*;
#(
    parameter int FILT_CYC = FILT_CYC_DEF
) (
    input  logic rclk,
    input  logic arst_l,
    input  logic pad_to_core,
    input  logic rx_en,
    input  logic rx_load,
    output logic rx_data,
    output logic rx_valid,
    output logic rx_rise,
    output logic rx_fall
);

    localparam logic [FILT_CW-1:0] FILT_LAST = FILT_CW'(FILT_CYC - 1);

    logic [1:0]         sync_pipe;
    logic               s2;
    logic [FILT_CW-1:0] mis_cnt;
    logic [FILT_CW-1:0] settle_cnt;

    assign s2 = sync_pipe[1];

    // Idle pad level is 1 (pull-up), so the synchroniser resets high.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) sync_pipe <= 2'b11;
        else         sync_pipe <= {sync_pipe[0], pad_to_core};
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            rx_data    <= 1'b1;
            rx_valid   <= 1'b0;
            rx_rise    <= 1'b0;
            rx_fall    <= 1'b0;
            mis_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            rx_rise <= 1'b0;
            rx_fall <= 1'b0;
            if (rx_load) begin
                rx_data    <= s2;
                rx_valid   <= 1'b0;
                mis_cnt    <= '0;
                settle_cnt <= '0;
            end else if (!rx_en) begin
                rx_valid   <= 1'b0;
                mis_cnt    <= '0;
                settle_cnt <= '0;
            end else if (!rx_valid) begin
                // Settling: any change restarts the window without a pulse.
                if (s2 != rx_data) begin
                    rx_data    <= s2;
                    settle_cnt <= '0;
                end else if (settle_cnt == FILT_LAST) begin
                    rx_valid   <= 1'b1;
                    settle_cnt <= '0;
                end else begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end else if (s2 == rx_data) begin
                mis_cnt <= '0;
            end else if (mis_cnt == FILT_LAST) begin
                rx_data <= s2;
                mis_cnt <= '0;
                rx_rise <= s2;
                rx_fall <= ~s2;
            end else begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bw_io_cmos2_pad_ctl.sv
// CMOS2 bidirectional pad controller: drive/receive sequencing with turnaround.
module bw_io_cmos2_pad_ctl
    import bw_io_cmos2_pkg::*;
#(
    parameter int FILT_CYC = FILT_CYC_DEF,
    parameter int TA_CYC   = TA_CYC_DEF
) (
    input  logic rclk,
    input  logic arst_l,
    input  logic drv_en,
    input  logic drv_data,
    input  logic pad_to_core,
    output logic pad_oe,
    output logic pad_data,
    output logic rx_data,
    output logic rx_valid,
    output logic rx_rise,
    output logic rx_fall
);

    localparam logic [TA_CW-1:0] TA_LAST = TA_CW'(TA_CYC - 1);

    pad_st_t          state;
    pad_st_t          nxt;
    logic [TA_CW-1:0] ta_cnt;
    logic             rx_en;
    logic             rx_load;

    always_comb begin
        nxt = state;
        case (state)
            ST_RX:    if (drv_en) nxt = ST_DRIVE;
            ST_DRIVE: if (!drv_en) nxt = ST_TURN;
            ST_TURN: begin
                if (drv_en)                 nxt = ST_DRIVE;
                else if (ta_cnt == TA_LAST) nxt = ST_RX;
            end
            default:  nxt = ST_RX;
        endcase
    end

    // pad_oe follows the next state so the pad switches on the same edge as the FSM.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state    <= ST_RX;
            ta_cnt   <= '0;
            pad_oe   <= 1'b0;
            pad_data <= 1'b0;
        end else begin
            state  <= nxt;
            ta_cnt <= (state == ST_TURN && nxt == ST_TURN) ? ta_cnt + 1'b1 : '0;
            pad_oe <= (nxt == ST_DRIVE);
            if (nxt == ST_DRIVE) pad_data <= drv_data;
        end
    end

    // A leaving transition wins over the filter on the same edge.
    assign rx_en   = (state == ST_RX) && (nxt == ST_RX);
    assign rx_load = (state != ST_RX) && (nxt == ST_RX);

    bw_io_cmos2_rx_filt #(
        .FILT_CYC (FILT_CYC)
    ) u_rx_filt (
        .rclk        (rclk),
        .arst_l      (arst_l),
        .pad_to_core (pad_to_core),
        .rx_en       (rx_en),
        .rx_load     (rx_load),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_rise     (rx_rise),
        .rx_fall     (rx_fall)
    );

endmodule

// File: tb/tb_bw_io_cmos2_pad_ctl.sv
// Scoreboard bench for bw_io_cmos2_pad_ctl against a behavioural pad model.
module tb_bw_io_cmos2_pad_ctl;

    localparam int FILT = 8;
    localparam int TA   = 2;

    logic rclk = 1'b0;
    logic arst_l = 1'b1;
    logic drv_en = 1'b0;
    logic drv_data = 1'b0;
    logic pad_to_core = 1'b1;
    logic pad_oe, pad_data, rx_data, rx_valid, rx_rise, rx_fall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        bit rise;
    } evt_t;
    evt_t exp_q[$];

    // Reference model state: low_run counts edges since drv_en was last seen high.
    int low_run = TA + 1;
    bit m_pd = 1'b0;
    bit m_rx = 1'b1;
    bit m_valid = 1'b0;
    int m_since = 0;
    bit sy1 = 1'b1;
    bit sy2 = 1'b1;
    bit s2q[$];

    bw_io_cmos2_pad_ctl #(.FILT_CYC(FILT), .TA_CYC(TA)) dut (
        .rclk        (rclk),
        .arst_l      (arst_l),
        .drv_en      (drv_en),
        .drv_data    (drv_data),
        .pad_to_core (pad_to_core),
        .pad_oe      (pad_oe),
        .pad_data    (pad_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_rise     (rx_rise),
        .rx_fall     (rx_fall)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit s2, was_rx, now_rx, hit, dummy;
        if (!arst_l) begin
            low_run = TA + 1; m_pd = 0; m_rx = 1; m_valid = 0; m_since = 0;
            sy1 = 1; sy2 = 1; s2q.delete();
            return;
        end
        cyc++;
        s2 = sy2; sy2 = sy1; sy1 = pad_to_core;
        was_rx = (low_run > TA);
        if (drv_en) begin
            low_run = 0;
            m_pd = drv_data;
        end else if (low_run <= TA) begin
            low_run++;
        end
        now_rx = (low_run > TA);
        s2q.push_back(s2);
        if (s2q.size() > FILT) dummy = s2q.pop_front();
        if (!now_rx) begin
            m_valid = 0; m_since = 0;
        end else if (!was_rx) begin
            m_rx = s2; m_valid = 0; m_since = 0;
        end else if (!m_valid) begin
            if (s2 != m_rx) begin
                m_rx = s2; m_since = 0;
            end else begin
                m_since++;
                if (m_since == FILT) begin m_valid = 1; m_since = 0; end
            end
        end else begin
            // Accept when the last FILT samples inside the window all disagree.
            if (m_since < FILT) m_since++;
            hit = (m_since == FILT);
            foreach (s2q[i]) if (s2q[i] == m_rx) hit = 0;
            if (hit) begin
                exp_q.push_back('{cyc, !m_rx});
                m_rx = !m_rx;
                m_since = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge rclk or negedge arst_l);
        model_step();
    end

    initial forever begin
        evt_t e;
        @(negedge rclk);
        chk("pad_oe", pad_oe, low_run == 0);
        chk("pad_data", pad_data, m_pd);
        chk("rx_data", rx_data, m_rx);
        chk("rx_valid", rx_valid, m_valid);
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missed_pulse_cycle", cyc, e.cyc);
        end
        if (rx_rise || rx_fall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {rx_rise, rx_fall}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_dir", {rx_rise, rx_fall}, e.rise ? 2 : 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    initial begin
        #1 arst_l = 1'b0;
        #5;
        chk("rst_pad_oe", pad_oe, 0);
        chk("rst_rx_data", rx_data, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_pulses", {rx_rise, rx_fall}, 0);
        @(negedge rclk);
        arst_l = 1'b1;
        tick(12);

        // Held fall, held rise, then a 7-cycle low glitch.
        pad_to_core = 1'b0; tick(15);
        pad_to_core = 1'b1; tick(15);
        pad_to_core = 1'b0; tick(7);
        pad_to_core = 1'b1; tick(15);

        drv_en = 1'b1; drv_data = 1'b0; tick(1);
        chk("drv_pad_oe", pad_oe, 1);
        chk("drv_pad_data", pad_data, 0);
        drv_data = 1'b1; tick(3);
        drv_en = 1'b0; tick(14);

        // Reassert in the first turnaround cycle, repeatedly.
        drv_en = 1'b1; tick(2);
        for (int i = 0; i < 10; i++) begin
            drv_en = 1'b0; tick(1);
            drv_en = 1'b1; drv_data = 1'(i); tick(1);
        end
        chk("toggle_rx_valid", rx_valid, 0);
        drv_en = 1'b0; tick(20);

        // Async reset while driving with rx_data held low.
        pad_to_core = 1'b0; tick(25);
        drv_en = 1'b1; tick(3);
        @(negedge rclk);
        #2 arst_l = 1'b0;
        #1;
        chk("arst_pad_oe", pad_oe, 0);
        chk("arst_rx_data", rx_data, 1);
        chk("arst_rx_valid", rx_valid, 0);
        drv_en = 1'b0;
        tick(2);
        @(negedge rclk);
        arst_l = 1'b1;
        tick(20);

        for (int b = 0; b < 300; b++) begin
            pad_to_core = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                drv_en = 1'b1;
                drv_data = 1'($urandom_range(0, 1));
                tick($urandom_range(1, 6));
            end else begin
                drv_en = 1'b0;
                tick($urandom_range(1, 20));
            end
        end

        drv_en = 1'b0; pad_to_core = 1'b1;
        tick(40);
        chk("pending_pulses", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
